// File: rtl/flash_op_sequencer.sv
// flash_op_sequencer
//   Owns the SPI flash bus and runs one erase operation per request:
//   WREN frame, erase command frame, then RDSR polling until WIP clears
//   (or the poll budget runs out). SPI mode 3, SCK = sys_clk/4.
// Ports
//   sys_clk, rst_n      clock, async active-low reset
//   req, op, addr       request handshake (sampled in IDLE only)
//   busy, done, err     status; err is qualified by done
//   MISO, MOSI, cs_n, sck  flash pins
module flash_op_sequencer #(
  parameter int CS_GAP   = 16,
  parameter int POLL_MAX = 4096
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [1:0]  op,
  input  logic [23:0] addr,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic        MISO,
  output logic        MOSI,
  output logic        cs_n,
  output logic        sck
);

  localparam int PCW = ($clog2(POLL_MAX + 1) > 13) ? $clog2(POLL_MAX + 1) : 13;
  localparam int CW  = 16;

  typedef enum logic [2:0] {S_IDLE, S_WREN, S_GAP, S_CMD, S_POLL, S_DONE} state_t;

  state_t          state, state_n, ret_q;
  logic [1:0]      op_q;
  logic [23:0]     addr_q;
  logic            err_q;
  logic [PCW-1:0]  poll_cnt, poll_inc;
  logic [CW-1:0]   cnt, frame_last;
  logic [31:0]     tx_sh, tx_load;
  logic [7:0]      rx_sh;
  logic [5:0]      nbits;
  logic            in_frame, frame_end, frame_start, gap_end, bit_zone;
  logic            wip, timeout;

  // Frame timing: cnt runs from cs_n fall. 4 lead cycles, 4 cycles per bit,
  // 4 tail cycles; the frame's last cycle is cnt == 7 + 4*nbits.
  always_comb begin
    case (state)
      S_WREN:  nbits = 6'd8;
      S_CMD:   nbits = (op_q == 2'b01) ? 6'd8 : 6'd32;
      S_POLL:  nbits = 6'd16;
      default: nbits = 6'd8;
    endcase
  end

  assign in_frame   = (state == S_WREN) || (state == S_CMD) || (state == S_POLL);
  assign frame_last = CW'(7) + CW'({nbits, 2'b00});
  assign frame_end  = in_frame && (cnt == frame_last);
  assign bit_zone   = in_frame && (cnt >= CW'(4)) && (cnt < frame_last - CW'(3));
  assign gap_end    = (state == S_GAP) && (cnt == CW'(CS_GAP - 1));
  assign poll_inc   = (poll_cnt == '1) ? poll_cnt : poll_cnt + 1'b1;
  // rx_sh holds the last 8 bits clocked in, i.e. the status byte after RDSR.
  assign wip        = rx_sh[0];
  assign timeout    = (poll_inc >= PCW'(POLL_MAX));

  always_comb begin
    if (state == S_IDLE) tx_load = {8'h06, 24'h0};
    else if (ret_q == S_CMD)
      tx_load = (op_q == 2'b00) ? {8'hD8, addr_q} : {8'hC7, 24'h0};
    else tx_load = {8'h05, 24'h0};
  end

  // state register
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // next-state logic
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (req) state_n = op[1] ? S_DONE : S_WREN;
      S_WREN,
      S_CMD:   if (frame_end) state_n = S_GAP;
      S_GAP:   if (gap_end) state_n = ret_q;
      S_POLL:  if (frame_end) state_n = (wip && !timeout) ? S_GAP : S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // outputs
  always_comb begin
    busy        = (state != S_IDLE);
    done        = (state == S_DONE);
    err         = (state == S_DONE) && err_q;
    frame_start = ((state == S_IDLE) && req && !op[1]) || gap_end;
  end

  // bus datapath
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= 2'b00;
      addr_q   <= 24'h0;
      err_q    <= 1'b0;
      poll_cnt <= '0;
      cnt      <= '0;
      tx_sh    <= 32'h0;
      rx_sh    <= 8'h0;
      ret_q    <= S_CMD;
      cs_n     <= 1'b1;
      sck      <= 1'b1;
      MOSI     <= 1'b0;
    end else begin
      if ((state == S_IDLE) && req) begin
        op_q     <= op;
        addr_q   <= addr;
        err_q    <= op[1];
        poll_cnt <= '0;
      end
      if (frame_start) begin
        cs_n  <= 1'b0;
        cnt   <= '0;
        tx_sh <= tx_load;
        rx_sh <= 8'h0;
      end else if (frame_end) begin
        cs_n  <= 1'b1;
        cnt   <= '0;
        ret_q <= (state == S_WREN) ? S_CMD : S_POLL;
        if (state == S_POLL) begin
          poll_cnt <= poll_inc;
          if (wip && timeout) err_q <= 1'b1;
        end
      end else if (in_frame || (state == S_GAP)) begin
        cnt <= cnt + CW'(1);
      end
      if (bit_zone) begin
        case (cnt[1:0])
          2'd0: begin sck <= 1'b0; MOSI <= tx_sh[31]; end
          2'd2: begin sck <= 1'b1; rx_sh <= {rx_sh[6:0], MISO}; end
          2'd3: tx_sh <= {tx_sh[30:0], 1'b0};
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_flash_op_sequencer.sv
module tb_flash_op_sequencer;
  logic        sys_clk = 1'b0;
  logic        rst_n = 1'b0, req = 1'b0, MISO = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [23:0] addr = 24'h0;
  logic        busy, done, err, MOSI, cs_n, sck;

  int tests = 0, fails = 0;

  flash_op_sequencer #(.CS_GAP(16), .POLL_MAX(4)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .req(req), .op(op), .addr(addr),
    .busy(busy), .done(done), .err(err), .MISO(MISO), .MOSI(MOSI),
    .cs_n(cs_n), .sck(sck)
  );

  always #5 sys_clk = ~sys_clk;

  // flash model / bus monitor; sole owner of its state
  int          cyc = 0, nfrm = 0, bitcnt = 0, rdsr_n = 0, sck_falls = 0, sck_bad = 0;
  int          rise_cyc = -1, k;
  logic [31:0] shv = 32'h0;
  logic [31:0] frm_val [0:63];
  int          frm_len [0:63];
  int          frm_gap [0:63];
  logic        prev_cs = 1'b1, prev_sck = 1'b1;
  logic [7:0]  cur_status = 8'h0;
  // status script, written by the stimulus block
  logic [7:0]  stat_seq [0:7];
  int          nstat = 0, stat_start = 0;
  logic [7:0]  stat_def = 8'h00;

  always @(negedge sys_clk) begin
    cyc++;
    if (prev_cs && !cs_n) begin
      bitcnt = 0; shv = 32'h0;
      if (nfrm < 64) frm_gap[nfrm] = (rise_cyc >= 0) ? cyc - rise_cyc : -1;
    end
    if (!prev_cs && cs_n) begin
      if (nfrm < 64) begin frm_val[nfrm] = shv; frm_len[nfrm] = bitcnt; end
      nfrm++;
      rise_cyc = cyc;
    end
    if (!cs_n && !prev_sck && sck) begin
      shv = {shv[30:0], MOSI};
      bitcnt++;
    end
    if (prev_sck && !sck) begin
      sck_falls++;
      if (cs_n) sck_bad++;
      if (bitcnt == 8 && shv[7:0] == 8'h05) begin
        k = rdsr_n - stat_start;
        cur_status = (k < nstat) ? stat_seq[k] : stat_def;
        rdsr_n++;
      end
      MISO = (bitcnt >= 8 && bitcnt < 16) ? cur_status[15-bitcnt] : 1'b0;
    end
    prev_cs = cs_n; prev_sck = sck;
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic start_op(input logic [1:0] o, input logic [23:0] a);
    @(negedge sys_clk);
    req = 1'b1; op = o; addr = a;
    @(negedge sys_clk);
    req = 1'b0;
  endtask

  task automatic wait_done(output logic ok, output logic e, output int drops);
    ok = 1'b0; e = 1'b0; drops = 0;
    for (int i = 0; i < 20000; i++) begin
      if (done) begin ok = 1'b1; e = err; break; end
      if (!busy) drops++;
      @(negedge sys_clk);
    end
  endtask

  initial begin
    logic ok, e;
    int   drops, b, sf, n06;

    // reset state
    #12;
    chk("rst_cs_n", cs_n, 1); chk("rst_sck", sck, 1); chk("rst_mosi", MOSI, 0);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_err", err, 0);
    @(negedge sys_clk); rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    // 1: bulk erase, WIP 1,1,0
    stat_seq[0] = 8'h01; stat_seq[1] = 8'h01; stat_seq[2] = 8'h00; nstat = 3;
    stat_start = rdsr_n; stat_def = 8'h00; b = nfrm;
    start_op(2'b01, 24'h0);
    chk("t1_busy_next", busy, 1);
    wait_done(ok, e, drops);
    chk("t1_done", ok, 1); chk("t1_err", e, 0); chk("t1_busy_drops", drops, 0);
    @(negedge sys_clk);
    chk("t1_done_pulse", done, 0); chk("t1_busy_end", busy, 0);
    chk("t1_nfrm", nfrm - b, 5);
    chk("t1_wren", frm_val[b], 32'h06); chk("t1_wren_len", frm_len[b], 8);
    chk("t1_cmd", frm_val[b+1], 32'hC7); chk("t1_cmd_len", frm_len[b+1], 8);
    for (int i = 2; i < 5; i++) begin
      chk("t1_rdsr", frm_val[b+i], 32'h0500); chk("t1_rdsr_len", frm_len[b+i], 16);
    end

    // 2: sector erase 0x123456, WIP clear at first poll
    stat_seq[0] = 8'h00; nstat = 1; stat_start = rdsr_n; b = nfrm;
    start_op(2'b00, 24'h123456);
    wait_done(ok, e, drops);
    chk("t2_done", ok, 1); chk("t2_err", e, 0);
    @(negedge sys_clk);
    chk("t2_nfrm", nfrm - b, 3);
    chk("t2_cmd", frm_val[b+1], 32'hD8123456); chk("t2_cmd_len", frm_len[b+1], 32);
    chk("t2_rdsr", frm_val[b+2], 32'h0500);

    // 3: reserved op
    b = nfrm; sf = sck_falls;
    start_op(2'b10, 24'hABCDEF);
    chk("t3_done", done, 1); chk("t3_err", err, 1); chk("t3_busy", busy, 1);
    @(negedge sys_clk);
    chk("t3_done_pulse", done, 0); chk("t3_busy_end", busy, 0);
    repeat (10) @(negedge sys_clk);
    chk("t3_no_frames", nfrm - b, 0); chk("t3_no_sck", sck_falls - sf, 0);
    chk("t3_cs_n", cs_n, 1);

    // 4: status stuck 0xFF -> timeout after POLL_MAX frames
    nstat = 0; stat_def = 8'hFF; stat_start = rdsr_n; b = nfrm;
    start_op(2'b01, 24'h0);
    wait_done(ok, e, drops);
    chk("t4_done", ok, 1); chk("t4_err", e, 1);
    @(negedge sys_clk);
    chk("t4_nfrm", nfrm - b, 6); chk("t4_cs_n", cs_n, 1);
    stat_def = 8'h00;

    // 5: reset in the middle of the CMD frame
    nstat = 0; stat_start = rdsr_n; b = nfrm; ok = 1'b0;
    start_op(2'b00, 24'h654321);
    for (int i = 0; i < 2000; i++) begin
      if (nfrm - b == 1 && !cs_n && bitcnt >= 10) begin ok = 1'b1; break; end
      @(negedge sys_clk);
    end
    chk("t5_reach_bit10", ok, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_cs_n", cs_n, 1); chk("t5_sck", sck, 1); chk("t5_mosi", MOSI, 0);
    chk("t5_busy", busy, 0);
    repeat (2) @(negedge sys_clk);
    rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    stat_start = rdsr_n; b = nfrm;
    start_op(2'b01, 24'h0);
    wait_done(ok, e, drops);
    chk("t5_done", ok, 1); chk("t5_err", e, 0);
    @(negedge sys_clk);
    chk("t5_nfrm", nfrm - b, 3); chk("t5_cmd", frm_val[b+1], 32'hC7);

    // 6: req pulses while busy are ignored; CS_GAP measured
    stat_seq[0] = 8'h01; stat_seq[1] = 8'h00; nstat = 2; stat_start = rdsr_n; b = nfrm;
    start_op(2'b00, 24'h0A0B0C);
    for (int i = 0; i < 240; i++) begin
      req = (i % 37 == 5); op = 2'b01; addr = 24'hFFFFFF;
      @(negedge sys_clk);
    end
    req = 1'b0;
    wait_done(ok, e, drops);
    chk("t6_done", ok, 1); chk("t6_err", e, 0); chk("t6_busy_drops", drops, 0);
    repeat (40) @(negedge sys_clk);
    chk("t6_idle", busy, 0);
    chk("t6_nfrm", nfrm - b, 4);
    n06 = 0;
    for (int i = 0; i < 4; i++) if (frm_val[b+i] == 32'h06) n06++;
    chk("t6_one_wren", n06, 1);
    chk("t6_cmd", frm_val[b+1], 32'hD80A0B0C);
    for (int i = 1; i < 4; i++) chk("t6_gap", frm_gap[b+i], 16);
    chk("t6_sck_outside_cs", sck_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
